// File: rtl/bicubic_vmult_sched.sv
// Sequencer that shares one combinational 4-tap multiplier across four row passes and one
// column pass of a separable bicubic pixel. Rounding enabled by `BICUBIC_SCHED_ROUND_EN.
module bicubic_vmult_sched #(
    parameter int unsigned INTER_PRODUCT_WIDTH = 24,
    parameter int unsigned FRAC_BITS           = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [127:0]                   in_pix,
    input  logic [11:0]                    in_wx,
    input  logic [11:0]                    in_wy,
    output logic [2:0]                     mult_weight_1,
    output logic [2:0]                     mult_weight_2,
    output logic [2:0]                     mult_weight_3,
    output logic [2:0]                     mult_weight_4,
    output logic [8:0]                     mult_pixel_1,
    output logic [8:0]                     mult_pixel_2,
    output logic [8:0]                     mult_pixel_3,
    output logic [8:0]                     mult_pixel_4,
    input  logic [INTER_PRODUCT_WIDTH-1:0] mult_inner_product,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [7:0]                     out_data,
    output logic                           busy
);

    localparam int unsigned W = INTER_PRODUCT_WIDTH;

`ifdef BICUBIC_SCHED_ROUND_EN
    localparam int unsigned RoundTerm = 1 << (FRAC_BITS - 1);
`else
    localparam int unsigned RoundTerm = 0;
`endif

    localparam logic signed [W:0] RoundVal = (W+1)'(RoundTerm);
    localparam logic signed [W:0] MaxVal   = (W+1)'(255);

    typedef enum logic [2:0] {
        StIdle,
        StRow0,
        StRow1,
        StRow2,
        StRow3,
        StCol,
        StOut
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] pix_q;
    logic [11:0]  wx_q;
    logic [11:0]  wy_q;
    logic [7:0]   row_q [4];
    logic [7:0]   out_data_q;

    logic [1:0]   row_idx;
    logic [31:0]  row_pix;
    logic [2:0]   mult_w [4];
    logic [8:0]   mult_p [4];
    logic [7:0]   norm_val;

    // Extra sign bit keeps the rounding add from overflowing before the shift.
    function automatic logic [7:0] norm(input logic [W-1:0] x);
        logic signed [W:0] ext;
        logic signed [W:0] sh;
        ext = $signed({x[W-1], x}) + RoundVal;
        sh  = ext >>> FRAC_BITS;
        if (sh[W]) begin
            norm = 8'd0;
        end else if (sh > MaxVal) begin
            norm = 8'd255;
        end else begin
            norm = sh[7:0];
        end
    endfunction

    assign norm_val = norm(mult_inner_product);

    always_comb begin
        row_idx = 2'd0;
        unique case (state_q)
            StRow1:  row_idx = 2'd1;
            StRow2:  row_idx = 2'd2;
            StRow3:  row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    assign row_pix = pix_q[row_idx*32 +: 32];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            mult_w[k] = 3'd0;
            mult_p[k] = 9'd0;
        end
        unique case (state_q)
            StRow0, StRow1, StRow2, StRow3: begin
                for (int k = 0; k < 4; k++) begin
                    mult_w[k] = wx_q[3*k +: 3];
                    mult_p[k] = {1'b0, row_pix[8*k +: 8]};
                end
            end
            StCol: begin
                for (int k = 0; k < 4; k++) begin
                    mult_w[k] = wy_q[3*k +: 3];
                    mult_p[k] = {1'b0, row_q[k]};
                end
            end
            default: ;
        endcase
    end

    assign mult_weight_1 = mult_w[0];
    assign mult_weight_2 = mult_w[1];
    assign mult_weight_3 = mult_w[2];
    assign mult_weight_4 = mult_w[3];
    assign mult_pixel_1  = mult_p[0];
    assign mult_pixel_2  = mult_p[1];
    assign mult_pixel_3  = mult_p[2];
    assign mult_pixel_4  = mult_p[3];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StRow0;
            StRow0:  state_d = StRow1;
            StRow1:  state_d = StRow2;
            StRow2:  state_d = StRow3;
            StRow3:  state_d = StCol;
            StCol:   state_d = StOut;
            StOut:   if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            pix_q      <= '0;
            wx_q       <= '0;
            wy_q       <= '0;
            out_data_q <= '0;
            for (int r = 0; r < 4; r++) row_q[r] <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        pix_q <= in_pix;
                        wx_q  <= in_wx;
                        wy_q  <= in_wy;
                    end
                end
                StRow0, StRow1, StRow2, StRow3: row_q[row_idx] <= norm_val;
                StCol:   out_data_q <= norm_val;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StOut);
    assign out_data  = out_data_q;

endmodule

// File: doc/bicubic_vmult_sched.md
# bicubic_vmult_sched

Sequencer that time-shares one external 4-tap bicubic vector multiplier to compute one separable bicubic output pixel from a 4x4 source window.
- **Horizontal pass:** 4 passes, one per window row, using horizontal weight indices.
- **Vertical pass:** 1 pass over the 4 normalized row results, using vertical weight indices.
- **Placement:** between the window-fetch stage and the output pixel stream, one instance per colour channel.
- **Multiplier:** combinational, instantiated beside this block and driven through the `mult_*` ports.

## Interface
Parameters:
- `INTER_PRODUCT_WIDTH`, 24: width of the multiplier inner product.
- `FRAC_BITS`, 10: fractional bits of the weight fixed-point format; normalization shift.

Ports:
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `in_valid`, input, 1: window and weights valid.
- `in_ready`, output, 1: block accepts a window.
- `in_pix`, input, 128: 4x4 window of 8-bit unsigned pixels. p[r][c] = `in_pix[(r*4+c)*8 +: 8]`.
- `in_wx`, input, 12: horizontal weight indices. Index k = `in_wx[3k +: 3]`.
- `in_wy`, input, 12: vertical weight indices, same packing.
- `mult_weight_1..4`, output, 3 each: to the shared multiplier.
- `mult_pixel_1..4`, output, 9 each: to the shared multiplier; zero-extended 8-bit values.
- `mult_inner_product`, input, `INTER_PRODUCT_WIDTH`: multiplier result, two's complement.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: downstream accepts the result.
- `out_data`, output, 8: interpolated pixel.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- States: IDLE, ROW0, ROW1, ROW2, ROW3, COL, OUT.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid`, latch `in_pix`, `in_wx` and `in_wy` into internal registers and go to ROW0.
- **ROWr**
  - Drive `mult_weight_k` = wx[k-1] and `mult_pixel_k` = {1'b0, p[r][k-1]}.
  - At the clock edge, store norm(`mult_inner_product`) into `row_reg[r]`.
  - Advance to ROW(r+1); ROW3 advances to COL.
- **COL**
  - Drive `mult_weight_k` = wy[k-1] and `mult_pixel_k` = {1'b0, `row_reg[k-1]`}.
  - At the clock edge, load `out_data` with the normalized result and go to OUT.
- **OUT**
  - `out_valid` = 1; `out_data` is held stable.
  - Leave for IDLE only when `out_ready` = 1.
- **Multiplier ports in IDLE and OUT:** all `mult_weight` and `mult_pixel` outputs = 0.
- **norm(x):**
  - Sign-extend x by 1 bit, add the rounding term (see Configuration), then arithmetic shift right by `FRAC_BITS`.
  - If the result is < 0, output 0. If the result is > 255, output 255. Otherwise output the low 8 bits.
- **Boundary cases:**
  - In every state except IDLE, `in_ready` = 0 and `in_valid` is ignored. No queuing.
  - The captured window is immune to input changes after acceptance.
  - `rst` asserted mid-operation aborts the computation and discards the partial `row_reg` contents.

## Timing
- **Reset values:**
  - State = IDLE.
  - `in_ready` = 1, `busy` = 0, `out_valid` = 0, `out_data` = 0.
  - `row_reg` = 0; `mult_*` = 0.
- **Latency:** accept at edge N puts ROW0 in cycle N+1. `out_valid` rises after edge N+5.
- **Throughput:** one result per 7 cycles when `out_ready` is held high. OUT with `out_ready` = 1 returns to IDLE, and IDLE can accept at the next edge.
- **Timing path:** the multiplier is combinational in the same cycle. The path runs from `mult_*` outputs through the external multiplier to `mult_inner_product`, then norm, then a register.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.

## Configuration
- Macro: `BICUBIC_SCHED_ROUND_EN`.
- **Defined:** norm adds 2^(`FRAC_BITS`-1) before the shift (round half up), in both the row and column passes.
- **Undefined:** the rounding term is 0 (truncation toward minus infinity). No other behaviour changes.

## Test plan
All scenarios use a bench stub multiplier (inner product = Σ weight·pixel, unsigned) and `FRAC_BITS` = 2.
- **Uniform window:** all pixels 100, wx = wy = {1,1,1,1}, `out_ready` = 1 → `out_data` = 100, with `out_valid` high exactly 5 edges after acceptance.
- **Upper clamp:** all pixels 255, all weights 7 → each row result 1785 clamps to 255 → `out_data` = 255.
- **Lower clamp:** stub forced to return 24'hFFFFF0 → `out_data` = 0.
- **Rounding:** every row = {0,0,1,1}, all weights 1.
  - Macro undefined → rows normalize to 0 → `out_data` = 0.
  - Macro defined → rows normalize to 1 → `out_data` = 1.
- **Backpressure:**
  - Hold `out_ready` = 0 for 10 cycles in OUT while `in_valid` = 1 → `in_ready` stays 0 and `out_data` is stable.
  - Then release `out_ready` → the next window is accepted 1 cycle after the OUT handshake.
- **Reset mid-operation:** assert `rst` during ROW2 → outputs immediately take their reset values. The next window computes correctly with no contamination from the aborted one.
